lynx_ram_arbiter: RTL and testbench

Three-port arbiter and sequencer that shares the single `ssdram` controller between the video fetch, the Z80 CPU and the tape/loader DMA engine. It latches one request at a time, drives the SDRAM controller's `cs/oe/we` strobes for a fixed access window and captures read data. It then returns a one-cycle acknowledge to the winning requester. It sits between the `lynx48` core memory buses and `ssdram`, in the `clk_sdram` domain.

---
 rtl/lynx_ram_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_lynx_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lynx_ram_arbiter.sv
// Three-port video/CPU/DMA arbiter and fixed-window sequencer in front of ssdram.
// Define LYNX_ARB_STARVE_EN to add the DMA starvation guard.
module lynx_ram_arbiter #(
  parameter int AW            = 18,
  parameter int ACCESS_CYCLES = 6,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          vid_req_i,
  input  logic          cpu_req_i,
  input  logic          dma_req_i,
  input  logic          vid_we_i,
  input  logic          cpu_we_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] vid_addr_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [7:0]    cpu_din_i,
  input  logic [7:0]    dma_din_i,
  output logic          vid_ack_o,
  output logic          cpu_ack_o,
  output logic          dma_ack_o,
  output logic [7:0]    rdata_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [7:0]    ram_data_o,
  output logic          ram_cs_o,
  output logic          ram_oe_o,
  output logic          ram_we_o,
  input  logic [7:0]    ram_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] OWN_VID  = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t        state_r, state_s;
  logic [3:0]    cnt_r, cnt_s;
  logic [1:0]    owner_r, owner_s;
  logic          we_r, we_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [7:0]    wdata_r, wdata_s;
  logic [7:0]    rdata_r, rdata_s;
  logic          cs_r, cs_s;
  logic          oe_r, oe_s;
  logic          ram_we_r, ram_we_s;
  logic          vid_ack_r, vid_ack_s;
  logic          cpu_ack_r, cpu_ack_s;
  logic          dma_ack_r, dma_ack_s;
  logic          any_req_s;
  logic          dma_force_s;
  logic          unused_s;

  // Video is read-only, so its write flag is deliberately left unconnected.
  assign unused_s  = vid_we_i;
  assign any_req_s = vid_req_i | cpu_req_i | dma_req_i;

`ifdef LYNX_ARB_STARVE_EN
  logic [2:0] starve_r, starve_s;
  assign dma_force_s = dma_req_i & (starve_r == 3'(STARVE_LIMIT));
`else
  assign dma_force_s = 1'b0;
`endif

  // Next-state, grant selection and next values of every registered output.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    owner_s  = owner_r;
    we_s     = we_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    rdata_s  = rdata_r;
    cs_s     = 1'b0;
    oe_s     = 1'b0;
    ram_we_s = 1'b0;
    vid_ack_s = 1'b0;
    cpu_ack_s = 1'b0;
    dma_ack_s = 1'b0;
`ifdef LYNX_ARB_STARVE_EN
    starve_s = starve_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_ACCESS;
          cnt_s   = CNT_LOAD;
          if (dma_force_s) begin
            owner_s = OWN_DMA;
            we_s    = dma_we_i;
            addr_s  = dma_addr_i;
            wdata_s = dma_din_i;
          end else if (vid_req_i) begin
            owner_s = OWN_VID;
            we_s    = 1'b0;
            addr_s  = vid_addr_i;
            wdata_s = 8'h00;
          end else if (cpu_req_i) begin
            owner_s = OWN_CPU;
            we_s    = cpu_we_i;
            addr_s  = cpu_addr_i;
            wdata_s = cpu_din_i;
          end else begin
            owner_s = OWN_DMA;
            we_s    = dma_we_i;
            addr_s  = dma_addr_i;
            wdata_s = dma_din_i;
          end
          cs_s     = 1'b1;
          oe_s     = ~we_s;
          ram_we_s = we_s;
`ifdef LYNX_ARB_STARVE_EN
          if (owner_s == OWN_DMA) begin
            starve_s = 3'd0;
          end else if (dma_req_i) begin
            starve_s = starve_r + 3'd1;
          end else begin
            starve_s = starve_r;
          end
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_DONE;
          if (!we_r) begin
            rdata_s = ram_data_i;
          end else begin
            rdata_s = rdata_r;
          end
          case (owner_r)
            OWN_VID: vid_ack_s = 1'b1;
            OWN_CPU: cpu_ack_s = 1'b1;
            OWN_DMA: dma_ack_s = 1'b1;
            default: vid_ack_s = 1'b0;
          endcase
        end else begin
          cnt_s    = cnt_r - 4'd1;
          cs_s     = 1'b1;
          oe_s     = ~we_r;
          ram_we_s = we_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access without an ack.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      owner_r   <= OWN_VID;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= 8'h00;
      rdata_r   <= 8'h00;
      cs_r      <= 1'b0;
      oe_r      <= 1'b0;
      ram_we_r  <= 1'b0;
      vid_ack_r <= 1'b0;
      cpu_ack_r <= 1'b0;
      dma_ack_r <= 1'b0;
`ifdef LYNX_ARB_STARVE_EN
      starve_r  <= 3'd0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      owner_r   <= owner_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      rdata_r   <= rdata_s;
      cs_r      <= cs_s;
      oe_r      <= oe_s;
      ram_we_r  <= ram_we_s;
      vid_ack_r <= vid_ack_s;
      cpu_ack_r <= cpu_ack_s;
      dma_ack_r <= dma_ack_s;
`ifdef LYNX_ARB_STARVE_EN
      starve_r  <= starve_s;
`endif
    end
  end

  assign vid_ack_o  = vid_ack_r;
  assign cpu_ack_o  = cpu_ack_r;
  assign dma_ack_o  = dma_ack_r;
  assign rdata_o    = rdata_r;
  assign ram_addr_o = addr_r;
  assign ram_data_o = wdata_r;
  assign ram_cs_o   = cs_r;
  assign ram_oe_o   = oe_r;
  assign ram_we_o   = ram_we_r;

endmodule

// File: tb/tb_lynx_ram_arbiter.sv
// Bench for lynx_ram_arbiter: transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_lynx_ram_arbiter;
  localparam int AW = 18;
  localparam int A  = 6;
  localparam int SL = 4;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          vid_req_i = 1'b0, cpu_req_i = 1'b0, dma_req_i = 1'b0;
  logic          vid_we_i = 1'b0, cpu_we_i = 1'b0, dma_we_i = 1'b0;
  logic [AW-1:0] vid_addr_i = '0, cpu_addr_i = '0, dma_addr_i = '0;
  logic [7:0]    cpu_din_i = 8'h00, dma_din_i = 8'h00;
  logic          vid_ack_o, cpu_ack_o, dma_ack_o;
  logic [7:0]    rdata_o;
  logic [AW-1:0] ram_addr_o;
  logic [7:0]    ram_data_o;
  logic          ram_cs_o, ram_oe_o, ram_we_o;
  logic [7:0]    ram_data_i = 8'h00;

  lynx_ram_arbiter #(.AW(AW), .ACCESS_CYCLES(A), .STARVE_LIMIT(SL)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .vid_req_i(vid_req_i), .cpu_req_i(cpu_req_i), .dma_req_i(dma_req_i),
    .vid_we_i(vid_we_i), .cpu_we_i(cpu_we_i), .dma_we_i(dma_we_i),
    .vid_addr_i(vid_addr_i), .cpu_addr_i(cpu_addr_i), .dma_addr_i(dma_addr_i),
    .cpu_din_i(cpu_din_i), .dma_din_i(dma_din_i),
    .vid_ack_o(vid_ack_o), .cpu_ack_o(cpu_ack_o), .dma_ack_o(dma_ack_o),
    .rdata_o(rdata_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_cs_o(ram_cs_o), .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o),
    .ram_data_i(ram_data_i)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  // Model: a granted transaction at cycle g owns strobes g+1..g+A and ack g+A+1.
  bit            chk_en = 1'b0;
  bit            has_cur = 1'b0;
  bit            m_we = 1'b0;
  bit            dma_forced;
  int            next_free = 0;
  int            cur_g = 0;
  int            m_starve = 0;
  int            m_own = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = 8'h00;
  logic [7:0]    m_rdata = 8'h00;

  always @(negedge clock_i) begin
    bit act;
    act = has_cur && (cyc >= cur_g + 1) && (cyc <= cur_g + A);
    if (chk_en) begin
      chk("cs", ram_cs_o, act);
      chk("oe", ram_oe_o, act && !m_we);
      chk("we", ram_we_o, act && m_we);
      chk("vid_ack", vid_ack_o, has_cur && (cyc == cur_g + A + 1) && (m_own == 0));
      chk("cpu_ack", cpu_ack_o, has_cur && (cyc == cur_g + A + 1) && (m_own == 1));
      chk("dma_ack", dma_ack_o, has_cur && (cyc == cur_g + A + 1) && (m_own == 2));
      chk("rdata", rdata_o, m_rdata);
      if (act) chk("addr", ram_addr_o, m_addr);
      if (act && m_we) chk("wdata", ram_data_o, m_data);
    end
    if (reset_i) begin
      chk_en = 1'b1;
      has_cur = 1'b0;
      next_free = cyc + 1;
      m_rdata = 8'h00;
      m_starve = 0;
    end else begin
      if (has_cur && (cyc == cur_g + A) && !m_we) m_rdata = ram_data_i;
      if (has_cur && (cyc == cur_g + A + 1)) has_cur = 1'b0;
      if (!has_cur && (cyc >= next_free) && (vid_req_i || cpu_req_i || dma_req_i)) begin
        dma_forced = 1'b0;
`ifdef LYNX_ARB_STARVE_EN
        dma_forced = dma_req_i && (m_starve == SL);
`endif
        if (dma_forced) m_own = 2;
        else if (vid_req_i) m_own = 0;
        else if (cpu_req_i) m_own = 1;
        else m_own = 2;
        case (m_own)
          0: begin m_we = 1'b0; m_addr = vid_addr_i; m_data = 8'h00; end
          1: begin m_we = cpu_we_i; m_addr = cpu_addr_i; m_data = cpu_din_i; end
          default: begin m_we = dma_we_i; m_addr = dma_addr_i; m_data = dma_din_i; end
        endcase
        if (m_own == 2) m_starve = 0;
        else if (dma_req_i) m_starve = (m_starve + 1) % 8;
        has_cur = 1'b1;
        cur_g = cyc;
        next_free = cyc + A + 2;
      end
    end
  end

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] ad, input logic [7:0] d);
    case (p)
      0: begin vid_req_i = 1'b1; vid_we_i = we; vid_addr_i = ad; end
      1: begin cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = ad; cpu_din_i = d; end
      default: begin dma_req_i = 1'b1; dma_we_i = we; dma_addr_i = ad; dma_din_i = d; end
    endcase
  endtask

  task automatic req_bit(input int p, input logic v);
    case (p)
      0: vid_req_i = v;
      1: cpu_req_i = v;
      default: dma_req_i = v;
    endcase
  endtask

  function automatic logic ack_of(input int p);
    case (p)
      0: return vid_ack_o;
      1: return cpu_ack_o;
      default: return dma_ack_o;
    endcase
  endfunction

  // Raise a request, scramble its inputs after the grant, wait for the ack
  // (bounded) and keep req high for 'extra' further cycles before dropping it.
  task automatic req_and_wait(input int p, input logic we, input logic [AW-1:0] ad,
                              input logic [7:0] d, input int extra,
                              output int start, output int ackc);
    @(posedge clock_i); #1;
    set_req(p, we, ad, d);
    start = cyc;
    ackc = -1;
    @(posedge clock_i); #1;
    set_req(p, we, ~ad, ~d);
    for (int i = 0; i < 40 && ackc < 0; i++) begin
      @(negedge clock_i);
      if (ack_of(p)) ackc = cyc;
    end
    repeat (extra + 1) begin @(posedge clock_i); #1; end
    req_bit(p, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a, a2, n;
    int ackat[3];
    int nack[3];
    bit lastack[3];

    repeat (3) @(posedge clock_i);
    #1 reset_i = 1'b0;
    @(negedge clock_i);
    chk("rst_cs", ram_cs_o, 1'b0);
    chk("rst_oe", ram_oe_o, 1'b0);
    chk("rst_we", ram_we_o, 1'b0);
    chk("rst_acks", {vid_ack_o, cpu_ack_o, dma_ack_o}, 3'b000);
    chk("rst_addr", ram_addr_o, 18'h00000);
    chk("rst_wdata", ram_data_o, 8'h00);
    chk("rst_rdata", rdata_o, 8'h00);

    // CPU read
    ram_data_i = 8'hA5;
    req_and_wait(1, 1'b0, 18'h00042, 8'h00, 0, s, a);
    chk("cpu_rd_latency", a - s, 7);
    chk("cpu_rd_data", rdata_o, 8'hA5);

    // CPU write: rdata must not move even though ram_data_i changes
    ram_data_i = 8'h3C;
    req_and_wait(1, 1'b1, 18'h01234, 8'h5A, 0, s, a);
    chk("cpu_wr_latency", a - s, 7);
    chk("cpu_wr_rdata_held", rdata_o, 8'hA5);

    // Simultaneous requests: video, CPU, DMA in order, 8 cycles apart
    ram_data_i = 8'h77;
    @(posedge clock_i); #1;
    set_req(0, 1'b0, 18'h00000, 8'h00);
    set_req(1, 1'b0, 18'h00100, 8'h00);
    set_req(2, 1'b1, 18'h3FFFF, 8'hC3);
    s = cyc;
    for (int p = 0; p < 3; p++) begin ackat[p] = -1; nack[p] = 0; lastack[p] = 1'b0; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock_i);
      for (int p = 0; p < 3; p++) begin
        lastack[p] = ack_of(p);
        if (lastack[p]) begin nack[p]++; ackat[p] = cyc; end
      end
      @(posedge clock_i); #1;
      for (int p = 0; p < 3; p++) if (lastack[p]) req_bit(p, 1'b0);
    end
    chk("sim_vid_at", ackat[0] - s, 7);
    chk("sim_cpu_at", ackat[1] - s, 15);
    chk("sim_dma_at", ackat[2] - s, 23);
    chk("sim_vid_n", nack[0], 1);
    chk("sim_cpu_n", nack[1], 1);
    chk("sim_dma_n", nack[2], 1);

    // DMA held while video and CPU alternate
    @(posedge clock_i); #1;
    set_req(0, 1'b0, 18'h00010, 8'h00);
    set_req(1, 1'b0, 18'h00020, 8'h00);
    set_req(2, 1'b0, 18'h00030, 8'h00);
    s = cyc;
    for (int p = 0; p < 3; p++) begin ackat[p] = -1; nack[p] = 0; lastack[p] = 1'b0; end
    for (int i = 0; i < 64; i++) begin
      @(negedge clock_i);
      for (int p = 0; p < 3; p++) begin
        lastack[p] = ack_of(p);
        if (lastack[p]) begin
          nack[p]++;
          if (ackat[p] < 0) ackat[p] = cyc;
        end
      end
      @(posedge clock_i); #1;
      vid_req_i = !lastack[0];
      cpu_req_i = !lastack[1];
      if (lastack[2]) dma_req_i = 1'b0;
    end
`ifdef LYNX_ARB_STARVE_EN
    chk("starve_dma_at", ackat[2] - s, 39);
    chk("starve_dma_n", nack[2], 1);
`else
    chk("nostarve_dma_n", nack[2], 0);
`endif
    vid_req_i = 1'b0;
    cpu_req_i = 1'b0;
    dma_req_i = 1'b0;
    repeat (10) @(posedge clock_i);

    // Reset during the third ACCESS cycle of a CPU read
    ram_data_i = 8'h99;
    @(posedge clock_i); #1;
    set_req(1, 1'b0, 18'h00ABC, 8'h00);
    s = cyc;
    repeat (3) begin @(posedge clock_i); #1; end
    reset_i = 1'b1;
    cpu_req_i = 1'b0;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("rstmid_cycle", cyc - s, 4);
    chk("rstmid_cs", ram_cs_o, 1'b0);
    chk("rstmid_rdata", rdata_o, 8'h00);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock_i);
      if (cpu_ack_o) n++;
    end
    chk("rstmid_noack", n, 0);
    req_and_wait(1, 1'b0, 18'h00ABC, 8'h00, 0, s, a);
    chk("rstmid_fresh_latency", a - s, 7);
    chk("rstmid_fresh_data", rdata_o, 8'h99);

    // CPU keeps req high one cycle past its ack: a second access follows
    ram_data_i = 8'h1E;
    req_and_wait(1, 1'b0, 18'h00555, 8'h00, 1, s, a);
    a2 = -1;
    for (int i = 0; i < 20 && a2 < 0; i++) begin
      @(negedge clock_i);
      if (cpu_ack_o) a2 = cyc;
    end
    chk("hold_first_latency", a - s, 7);
    chk("hold_second_gap", a2 - a, 8);
    chk("hold_second_data", rdata_o, 8'h1E);

    repeat (5) @(posedge clock_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
